eth_tx_frame_buf: RTL

// - Host-loaded Ethernet TX frame buffer. It is the AXI-stream master that drives the MAC tx_axis_* input.
// - Host writes a frame (dest MAC .. payload, no FCS) byte-wise into an internal RAM, then pulses start.
// - The block replays the frame onto tx_axis with tlast on the final byte. The MAC appends the FCS.
// - Sits in the 125 MHz MAC TX clock domain, between the host register interface and rgmii_core.

---
 rtl/eth_tx_frame_buf.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/eth_tx_frame_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_tx_frame_buf                                                           |
// | Host-loaded Ethernet TX frame buffer replayed as an AXI-stream master.     |
// | Optional short-frame zero padding to MIN_LEN: define ETH_TX_PAD_EN.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module eth_tx_frame_buf #(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 60
) (
  input  logic              clk_int,
  input  logic              rst_int,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        tx_axis_tdata,
  output logic              tx_axis_tvalid,
  input  logic              tx_axis_tready,
  output logic              tx_axis_tlast,
  output logic              tx_axis_tuser
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_depth   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_min_len = (ADDR_W+1)'(MIN_LEN);
`ifdef ETH_TX_PAD_EN
  localparam logic            c_pad_en  = 1'b1;
`else
  localparam logic            c_pad_en  = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_mem [DEPTH];
  logic [7:0]        r_rd_data;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_last_idx;
  logic [ADDR_W:0]   r_beat;
  logic              r_tlast;
  logic              r_tuser;
  logic              r_abort_pend;
  logic              r_done;
  logic              r_err;

  logic              w_hs;
  logic              w_last_hs;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_load;
  logic              w_abort_req;
  logic [ADDR_W:0]   w_load_idx;
  logic [ADDR_W:0]   w_total;
  logic [ADDR_W-1:0] w_rd_addr;

  // The read address tracks the beat that will be on the bus next cycle, so the
  // RAM output register acts as the prefetch stage and holds steady under stall.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_load      = 1'b0;
    w_load_idx  = r_beat + 1'b1;
    w_rd_addr   = '0;
    w_hs        = (r_state == ST_STREAM) && tx_axis_tready;
    w_last_hs   = w_hs && r_tlast;
    w_abort_req = abort || r_abort_pend;
    w_total     = (c_pad_en && (frame_len < c_min_len)) ? c_min_len : frame_len;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if ((frame_len != '0) && (frame_len <= c_depth)) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        w_load      = 1'b1;
        w_load_idx  = '0;
        w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_last_hs) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hs) begin
          w_load    = 1'b1;
          w_rd_addr = w_load_idx[ADDR_W-1:0];
        end else begin
          w_rd_addr = r_beat[ADDR_W-1:0];
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_int) begin
    if (wr_en && !busy) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_last_idx   <= '0;
      r_beat       <= '0;
      r_tlast      <= 1'b0;
      r_tuser      <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last_hs;
      r_err   <= w_start_bad || (w_last_hs && r_tuser);
      if (w_start_ok) begin
        r_len        <= frame_len;
        r_last_idx   <= w_total - 1'b1;
        r_abort_pend <= 1'b0;
      end
      // Beat attributes change only when a new beat is loaded, keeping them stable under stall.
      if (w_load) begin
        r_beat       <= w_load_idx;
        r_tlast      <= (w_load_idx == r_last_idx) || w_abort_req;
        r_tuser      <= w_abort_req;
        r_abort_pend <= 1'b0;
      end else if (abort && (r_state != ST_IDLE)) begin
        r_abort_pend <= 1'b1;
      end
      if (w_last_hs) begin
        r_tlast      <= 1'b0;
        r_tuser      <= 1'b0;
        r_abort_pend <= 1'b0;
      end
    end
  end

  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign err            = r_err;
  assign tx_axis_tvalid = (r_state == ST_STREAM);
  assign tx_axis_tlast  = r_tlast;
  assign tx_axis_tuser  = r_tuser;
  assign tx_axis_tdata  = (tx_axis_tvalid && (r_beat < r_len)) ? r_rd_data : 8'h00;

endmodule
`default_nettype wire
